// File: rtl/xgmii_rx_probe.sv
// xgmii_rx_probe: XGMII receive-side parser for UDP probe frames.
// It watches one 64-bit XGMII lane group, delimits frames, checks the probe fields,
// and extracts the TX timestamp and the IPv4 destination address. For the last good
// probe frame it reports the one-way latency and the destination address. It also
// reports the number of good frames and bytes seen in each one-second window.
//
// Ports
//   i_sys_clk         XGMII clock; all logic runs on its rising edge
//   i_sys_rst_n       asynchronous active-low reset
//   i_sec_oneshot     one-cycle pulse once per second; closes the rate window
//   i_global_counter  free-running timestamp counter shared with the TX stage
//   i_xgmii_rxd       XGMII data; byte n = rxd[8n+7:8n], byte 0 first on the wire
//   i_xgmii_rxc       XGMII control flags; bit n qualifies byte n
//   o_rx_pps          good frames counted in the previous window
//   o_rx_throughput   bytes (dst MAC through FCS) counted in the previous window
//   o_rx_latency      global_counter minus timestamp for the last good probe frame
//   o_rx_ipv4_ip      IPv4 destination address of the last good probe frame
module xgmii_rx_probe #(
  parameter logic [31:0] MAGIC_CODE = 32'hC0DE_CAFE,
  parameter logic [15:0] UDP_PORT   = 16'd9,
  parameter logic [11:0] MAX_WORDS  = 12'd2047
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst_n,
  input  logic        i_sec_oneshot,
  input  logic [31:0] i_global_counter,
  input  logic [63:0] i_xgmii_rxd,
  input  logic [7:0]  i_xgmii_rxc,
  output logic [31:0] o_rx_pps,
  output logic [31:0] o_rx_throughput,
  output logic [23:0] o_rx_latency,
  output logic [31:0] o_rx_ipv4_ip
);

  typedef enum logic [1:0] {StIdle, StFrame, StDrop} state_e;

  state_e r_state, w_state_d;

  logic [11:0] r_w;          // index of the current word after the preamble
  logic        r_probe_ok;
  logic [31:0] r_ip;
  logic [15:0] r_ts_hi;
  logic [23:0] r_lat;
  logic [31:0] r_pps_acc, r_byte_acc;
  logic [31:0] r_rx_pps, r_rx_thr, r_rx_ip;
  logic [23:0] r_rx_lat;

  // Lane decode
  logic [7:0]  w_byte [8];
  logic [2:0]  w_ctl_lane;
  logic        w_ctl_any, w_term, w_start, w_drop_exit, w_over;

  always_comb begin
    w_ctl_lane  = 3'd0;
    w_drop_exit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_byte[i] = i_xgmii_rxd[8*i +: 8];
    end
    // Lowest control lane decides the word: a terminate only counts when every
    // lane below it is data.
    for (int i = 7; i >= 0; i--) begin
      if (i_xgmii_rxc[i]) w_ctl_lane = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      if (i_xgmii_rxc[i] && (w_byte[i] == 8'hFD || w_byte[i] == 8'hFE)) w_drop_exit = 1'b1;
    end
  end

  assign w_ctl_any = |i_xgmii_rxc;
  assign w_term    = w_ctl_any && (w_byte[w_ctl_lane] == 8'hFD);
  assign w_start   = i_xgmii_rxc[0] && (w_byte[0] == 8'hFB);
  assign w_over    = r_w > MAX_WORDS;

  // FSM: state register
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) r_state <= StIdle;
    else              r_state <= w_state_d;
  end

  // FSM: next state
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_start) w_state_d = StFrame;
      end
      StFrame: begin
        if (w_start)        w_state_d = StFrame;
        else if (w_over)    w_state_d = StDrop;
        else if (w_ctl_any) w_state_d = w_term ? StIdle : StDrop;
      end
      StDrop: begin
        if (w_start)          w_state_d = StFrame;
        else if (w_drop_exit) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // FSM: outputs
  logic w_in_frame, w_frame_end, w_probe_upd;

  always_comb begin
    w_in_frame  = (r_state == StFrame) && !w_start && !w_over;
    w_frame_end = w_in_frame && w_term;
    w_probe_upd = w_frame_end && r_probe_ok && (r_w >= 12'd7);
  end

  // Field checks, indexed by word number
  logic w_chk_ok;

  always_comb begin
    w_chk_ok = 1'b1;
    case (r_w)
      12'd2: w_chk_ok = (w_byte[4] == 8'h08) && (w_byte[5] == 8'h00) && (w_byte[6] == 8'h45);
      12'd3: w_chk_ok = (w_byte[7] == 8'h11);
      12'd5: w_chk_ok = ({w_byte[4], w_byte[5]} == UDP_PORT);
      12'd6: w_chk_ok = ({w_byte[2], w_byte[3], w_byte[4], w_byte[5]} == MAGIC_CODE);
      default: w_chk_ok = 1'b1;
    endcase
  end

  // Latency is modulo 2^32, so a counter wrap between stamp and receive is harmless.
  logic [31:0] w_lat_full;
  logic [23:0] w_lat_now;
  logic        unused_lat_hi;

  assign w_lat_full    = i_global_counter - {r_ts_hi, w_byte[0], w_byte[1]};
  assign w_lat_now     = w_lat_full[23:0];
  assign unused_lat_hi = ^w_lat_full[31:24];

  // Length = 8*(w-1) + terminate lane
  logic [14:0] w_len;
  logic [31:0] w_pps_add, w_byte_add;
  logic [32:0] w_byte_sum;

  assign w_len      = {r_w - 12'd1, 3'b000} + {12'd0, w_ctl_lane};
  assign w_pps_add  = w_frame_end ? 32'd1 : 32'd0;
  assign w_byte_add = w_frame_end ? {17'd0, w_len} : 32'd0;
  assign w_byte_sum = {1'b0, r_byte_acc} + {1'b0, w_byte_add};

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_w        <= 12'd0;
      r_probe_ok <= 1'b0;
      r_ip       <= 32'd0;
      r_ts_hi    <= 16'd0;
      r_lat      <= 24'd0;
      r_pps_acc  <= 32'd0;
      r_byte_acc <= 32'd0;
      r_rx_pps   <= 32'd0;
      r_rx_thr   <= 32'd0;
      r_rx_lat   <= 24'd0;
      r_rx_ip    <= 32'd0;
    end else begin
      if (w_start) begin
        r_w        <= 12'd1;
        r_probe_ok <= 1'b1;
      end else if (w_in_frame) begin
        r_w        <= r_w + 12'd1;
        r_probe_ok <= r_probe_ok && w_chk_ok;
        case (r_w)
          12'd4: r_ip[31:16] <= {w_byte[6], w_byte[7]};
          12'd5: r_ip[15:0]  <= {w_byte[0], w_byte[1]};
          12'd6: r_ts_hi     <= {w_byte[6], w_byte[7]};
          12'd7: r_lat       <= w_lat_now;
          default: ;
        endcase
      end

      if (w_probe_upd) begin
        // A terminate inside word 7 has not yet latched the latency.
        r_rx_lat <= (r_w == 12'd7) ? w_lat_now : r_lat;
        r_rx_ip  <= r_ip;
      end

      // On the window edge the accumulators restart from the frame ending now, if any.
      if (i_sec_oneshot) begin
        r_rx_pps   <= r_pps_acc;
        r_rx_thr   <= r_byte_acc;
        r_pps_acc  <= w_pps_add;
        r_byte_acc <= w_byte_add;
      end else begin
        r_pps_acc  <= r_pps_acc + w_pps_add;
        r_byte_acc <= w_byte_sum[32] ? 32'hFFFF_FFFF : w_byte_sum[31:0];
      end
    end
  end

  assign o_rx_pps        = r_rx_pps;
  assign o_rx_throughput = r_rx_thr;
  assign o_rx_latency    = r_rx_lat;
  assign o_rx_ipv4_ip    = r_rx_ip;

endmodule

// File: tb/tb_xgmii_rx_probe.sv
// Testbench for xgmii_rx_probe: builds probe frames as byte arrays, streams them as
// XGMII words and compares the outputs with a frame-level reference model.
module tb_xgmii_rx_probe;

  localparam logic [31:0] MAGIC = 32'hC0DE_CAFE;
  localparam logic [15:0] DPORT = 16'd9;
  localparam int          MAXW  = 2047;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sec = 1'b0;
  logic [31:0] gcnt = 32'd0;
  logic [63:0] rxd = {8{8'h07}};
  logic [7:0]  rxc = 8'hFF;
  logic [31:0] pps, thr, ipo;
  logic [23:0] lat;

  xgmii_rx_probe #(
    .MAGIC_CODE(MAGIC),
    .UDP_PORT  (DPORT),
    .MAX_WORDS (12'(MAXW))
  ) dut (
    .i_sys_clk       (clk),
    .i_sys_rst_n     (rst_n),
    .i_sec_oneshot   (sec),
    .i_global_counter(gcnt),
    .i_xgmii_rxd     (rxd),
    .i_xgmii_rxc     (rxc),
    .o_rx_pps        (pps),
    .o_rx_throughput (thr),
    .o_rx_latency    (lat),
    .o_rx_ipv4_ip    (ipo)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] gc_free = 32'h100;
  logic [7:0]  fb [16384];

  // Reference model: frame-level counters and last-probe results
  logic [31:0] m_pps_acc = 0, m_byte_acc = 0, m_pps = 0, m_thr = 0, m_ip = 0;
  logic [23:0] m_lat = 0;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [63:0] d, input logic [7:0] c, input logic [31:0] g,
                       input logic s);
    rxd = d; rxc = c; gcnt = g; sec = s;
    @(posedge clk);
    #1;
    sec = 1'b0;
    gc_free = gc_free + 32'd1;
  endtask

  task automatic sec_word();
    drive({8{8'h07}}, 8'hFF, gc_free, 1'b1);
    m_pps = m_pps_acc; m_thr = m_byte_acc; m_pps_acc = 0; m_byte_acc = 0;
  endtask

  task automatic model_reset();
    m_pps_acc = 0; m_byte_acc = 0; m_pps = 0; m_thr = 0; m_ip = 0; m_lat = 0;
  endtask

  // kind: 0 good probe, 1 bad magic, 2 bad dport, 3 ethertype 86DD, 4 not UDP
  task automatic build_frame(input int len, input int kind, input logic [31:0] ip,
                             input logic [31:0] ts);
    logic [15:0] et, dp;
    logic [31:0] mg;
    logic [7:0]  pr;
    et = (kind == 3) ? 16'h86DD : 16'h0800;
    dp = (kind == 2) ? DPORT + 16'd1 : DPORT;
    mg = (kind == 1) ? MAGIC ^ 32'h0001_0000 : MAGIC;
    pr = (kind == 4) ? 8'h06 : 8'h11;
    for (int i = 0; i < len; i++) fb[i] = 8'($urandom);
    fb[12] = et[15:8]; fb[13] = et[7:0]; fb[14] = 8'h45; fb[23] = pr;
    fb[30] = ip[31:24]; fb[31] = ip[23:16]; fb[32] = ip[15:8]; fb[33] = ip[7:0];
    fb[36] = dp[15:8]; fb[37] = dp[7:0];
    fb[42] = mg[31:24]; fb[43] = mg[23:16]; fb[44] = mg[15:8]; fb[45] = mg[7:0];
    fb[46] = ts[31:24]; fb[47] = ts[23:16]; fb[48] = ts[15:8]; fb[49] = ts[7:0];
  endtask

  // inj: 0 none, 1 FE in lane 3 of word 4, 2 frame cut after word 4 (next start restarts)
  task automatic send_frame(input int len, input logic [31:0] gc7, input int inj,
                            input logic so);
    logic [63:0] d;
    logic [7:0]  c;
    int nfull, rem;
    nfull = len / 8;
    rem   = len % 8;
    drive(64'hD555_5555_5555_55FB, 8'h01, gc_free, 1'b0);
    for (int w = 1; w <= nfull; w++) begin
      if (inj == 2 && w == 5) return;
      for (int l = 0; l < 8; l++) d[8*l +: 8] = fb[(w-1)*8 + l];
      c = 8'h00;
      if (inj == 1 && w == 4) begin d[31:24] = 8'hFE; c[3] = 1'b1; end
      drive(d, c, (w == 7) ? gc7 : gc_free, 1'b0);
    end
    for (int l = 0; l < 8; l++) begin
      if (l < rem)       begin d[8*l +: 8] = fb[nfull*8 + l]; c[l] = 1'b0; end
      else if (l == rem) begin d[8*l +: 8] = 8'hFD;           c[l] = 1'b1; end
      else               begin d[8*l +: 8] = 8'h07;           c[l] = 1'b1; end
    end
    drive(d, c, gc_free, so);
  endtask

  // Build, send, and apply the spec rules to the model.
  task automatic frame(input int len, input int kind, input int inj, input logic so,
                       input logic [31:0] ip, input logic [31:0] ts, input logic [31:0] gc7);
    int  tw;
    bit  counted;
    longint s;
    build_frame(len, kind, ip, ts);
    send_frame(len, gc7, inj, so);
    if (inj == 2) return;
    tw = len / 8 + 1;
    counted = (inj == 0) && (tw <= MAXW);
    if (so) begin
      m_pps = m_pps_acc; m_thr = m_byte_acc; m_pps_acc = 0; m_byte_acc = 0;
    end
    if (counted) begin
      m_pps_acc = m_pps_acc + 1;
      s = longint'(m_byte_acc) + longint'(len);
      m_byte_acc = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
      if (kind == 0 && tw >= 7) begin
        m_lat = 24'(gc7 - ts);
        m_ip  = ip;
      end
    end
  endtask

  task automatic check_probe(input string tag);
    checks++;
    if (lat !== m_lat) begin
      errors++; $display("FAIL %s latency: got %h expected %h", tag, lat, m_lat);
    end
    checks++;
    if (ipo !== m_ip) begin
      errors++; $display("FAIL %s ipv4: got %h expected %h", tag, ipo, m_ip);
    end
  endtask

  task automatic check_rates(input string tag);
    checks++;
    if (pps !== m_pps) begin
      errors++; $display("FAIL %s pps: got %0d expected %0d", tag, pps, m_pps);
    end
    checks++;
    if (thr !== m_thr) begin
      errors++; $display("FAIL %s throughput: got %0d expected %0d", tag, thr, m_thr);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (pps !== 32'd0 || thr !== 32'd0 || lat !== 24'd0 || ipo !== 32'd0) begin
      errors++;
      $display("FAIL %s: got pps=%h thr=%h lat=%h ip=%h expected all 0", tag, pps, thr, lat,
               ipo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    model_reset();
    repeat (2) drive({8{8'h07}}, 8'hFF, gc_free, 1'b0);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_probe();
    frame(64, 0, 0, 1'b0, 32'h0A00_1569, 32'h0000_1000, 32'h0000_1064);
    checks++;
    if (lat !== 24'h000064) begin
      errors++; $display("FAIL probe64 latency: got %h expected 000064", lat);
    end
    checks++;
    if (ipo !== 32'h0A00_1569) begin
      errors++; $display("FAIL probe64 ipv4: got %h expected 0a001569", ipo);
    end
    sec_word();
    check_rates("probe64");
  endtask

  task automatic test_wrap();
    frame(72, 0, 0, 1'b0, 32'hC0A8_0001, 32'hFFFF_FFF0, 32'h0000_0010);
    checks++;
    if (lat !== 24'h000020) begin
      errors++; $display("FAIL wrap latency: got %h expected 000020", lat);
    end
  endtask

  task automatic test_bad_fields();
    for (int k = 1; k <= 4; k++) begin
      frame($urandom_range(64, 160), k, 0, 1'b0, $urandom, $urandom, $urandom);
      check_probe($sformatf("bad_field%0d", k));
    end
    sec_word();
    check_rates("bad_fields");
  endtask

  task automatic test_corrupt();
    frame(96, 0, 1, 1'b0, 32'h1111_1111, 32'h10, 32'h20);
    check_probe("fe_lane3");
    frame(96, 0, 2, 1'b0, 32'h2222_2222, 32'h10, 32'h30);
    frame(80, 0, 0, 1'b0, 32'h0A0B_0C0D, 32'h5000, 32'h5123);
    check_probe("after_restart");
    sec_word();
    check_rates("corrupt");
  endtask

  task automatic test_random();
    int inj, kind;
    logic so;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      inj  = ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 5) == 0) ? 2 : 0);
      so   = (inj != 2) && ($urandom_range(0, 7) == 0);
      frame($urandom_range(64, 200), kind, inj, so, $urandom, $urandom, $urandom);
      check_probe($sformatf("random%0d", n));
      if (so) check_rates($sformatf("random_sec%0d", n));
    end
    sec_word();
    check_rates("random_window");
  endtask

  task automatic test_back_to_back();
    sec_word();
    check_rates("b2b_pre");
    for (int n = 0; n < 1000; n++) frame(64, 0, 0, 1'b0, $urandom, $urandom, $urandom);
    check_probe("b2b_last");
    sec_word();
    checks++;
    if (pps !== 32'd1000) begin
      errors++; $display("FAIL b2b pps: got %0d expected 1000", pps);
    end
    checks++;
    if (thr !== 32'd64000) begin
      errors++; $display("FAIL b2b throughput: got %0d expected 64000", thr);
    end
  endtask

  task automatic test_sec_coincide();
    frame(64, 0, 0, 1'b0, $urandom, $urandom, $urandom);
    frame(120, 0, 0, 1'b1, $urandom, $urandom, $urandom);
    check_rates("coincide_window");
    sec_word();
    check_rates("coincide_next");
  endtask

  task automatic test_max_words();
    frame(8 * (MAXW - 1), 0, 0, 1'b0, 32'h0102_0304, 32'h100, 32'h180);
    check_probe("max_ok");
    frame(8 * MAXW, 0, 0, 1'b0, 32'h0506_0708, 32'h100, 32'h200);
    check_probe("max_over");
    sec_word();
    check_rates("max_words");
  endtask

  task automatic test_reset_mid();
    build_frame(96, 0, 32'h3333_3333, 32'h40);
    drive(64'hD555_5555_5555_55FB, 8'h01, gc_free, 1'b0);
    for (int w = 1; w <= 3; w++) drive({$urandom, $urandom}, 8'h00, gc_free, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    // Tail of the interrupted frame must be ignored from IDLE.
    for (int w = 0; w < 5; w++) drive({$urandom, $urandom}, 8'h00, gc_free, 1'b0);
    drive({{7{8'h07}}, 8'hFD}, 8'hFF, gc_free, 1'b0);
    frame(88, 0, 0, 1'b0, 32'h0A00_0001, 32'h7000, 32'h7077);
    check_probe("reset_mid_next");
    sec_word();
    check_rates("reset_mid_rates");
  endtask

  initial begin
    test_reset();
    test_probe();
    test_wrap();
    test_bad_fields();
    test_corrupt();
    test_random();
    test_back_to_back();
    test_sec_coincide();
    test_max_words();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
